// File: rtl/id_control_seq.sv
// Registered decode/control stage between register read and ID/EX.
// Block transfers are expanded into one memory micro-op per listed register.
//   state | meaning
//   IDLE  | decoder ready; single-cycle ops and first block micro-op issue here
//   SEQ   | issuing the remaining micro-ops of a block transfer
module id_control_seq #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int OFF_W    = IDX_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                instr_valid,
  input  logic [1:0]          mode,
  input  logic [3:0]          op_code,
  input  logic                s_in,
  input  logic [NUM_REGS-1:0] reg_list,
  output logic                ready,
  output logic                valid_out,
  output logic [3:0]          exe_cmd,
  output logic                mem_read,
  output logic                mem_write,
  output logic                wb_en,
  output logic                b,
  output logic                s_out,
  output logic [IDX_W-1:0]    xfer_reg,
  output logic [OFF_W-1:0]    xfer_offset,
  output logic                xfer_last
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t              state, state_nxt;
  logic [NUM_REGS-1:0] rem_mask, rem_nxt;
  logic [IDX_W:0]      ordinal, ord_nxt;
  logic                l_bit, l_nxt;
  logic                accept;
  logic [NUM_REGS-1:0] src, src_low, src_rest;
  logic [IDX_W-1:0]    low_idx;
  logic                uop_l;
  logic [IDX_W:0]      uop_ord;

  logic                valid_d, mr_d, mw_d, wb_d, b_d, s_d, last_d;
  logic [3:0]          cmd_d;
  logic [IDX_W-1:0]    reg_d;
  logic [OFF_W-1:0]    off_d;

  assign ready    = (state == IDLE);
  assign accept   = instr_valid & ready & ~freeze & ~flush;
  // In IDLE the micro-op source is the incoming list, in SEQ the remaining mask
  assign src      = (state == IDLE) ? reg_list : rem_mask;
  assign src_low  = src & (~src + NUM_REGS'(1));
  assign src_rest = src & ~src_low;
  assign uop_l    = (state == SEQ) ? l_bit : s_in;
  assign uop_ord  = (state == SEQ) ? ordinal : '0;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (src[i]) low_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_mask    <= '0;
      ordinal     <= '0;
      l_bit       <= 1'b0;
      valid_out   <= 1'b0;
      exe_cmd     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      wb_en       <= 1'b0;
      b           <= 1'b0;
      s_out       <= 1'b0;
      xfer_reg    <= '0;
      xfer_offset <= '0;
      xfer_last   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rem_mask    <= rem_nxt;
      ordinal     <= ord_nxt;
      l_bit       <= l_nxt;
      valid_out   <= valid_d;
      exe_cmd     <= cmd_d;
      mem_read    <= mr_d;
      mem_write   <= mw_d;
      wb_en       <= wb_d;
      b           <= b_d;
      s_out       <= s_d;
      xfer_reg    <= reg_d;
      xfer_offset <= off_d;
      xfer_last   <= last_d;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem_mask;
    ord_nxt   = ordinal;
    l_nxt     = l_bit;
    if (flush) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      ord_nxt   = '0;
    end else if (!freeze) begin
      case (state)
        IDLE: if (accept && mode == 2'b11 && src_rest != '0) begin
          state_nxt = SEQ;
          rem_nxt   = src_rest;
          ord_nxt   = (IDX_W+1)'(1);
          l_nxt     = s_in;
        end
        SEQ: begin
          rem_nxt = src_rest;
          ord_nxt = ordinal + (IDX_W+1)'(1);
          if (src_rest == '0) begin
            state_nxt = IDLE;
            ord_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = 1'b0;
    cmd_d   = 4'b0000;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    wb_d    = 1'b0;
    b_d     = 1'b0;
    s_d     = 1'b0;
    reg_d   = '0;
    off_d   = '0;
    last_d  = 1'b0;
    if (flush) begin
      valid_d = 1'b0;
    end else if (freeze) begin
      valid_d = valid_out;
      cmd_d   = exe_cmd;
      mr_d    = mem_read;
      mw_d    = mem_write;
      wb_d    = wb_en;
      b_d     = b;
      s_d     = s_out;
      reg_d   = xfer_reg;
      off_d   = xfer_offset;
      last_d  = xfer_last;
    end else if (state == SEQ || (accept && mode == 2'b11 && src != '0)) begin
      valid_d = 1'b1;
      cmd_d   = 4'b0010;
      mr_d    = uop_l;
      mw_d    = ~uop_l;
      wb_d    = uop_l;
      reg_d   = low_idx;
      off_d   = OFF_W'(uop_ord) << 2;
      last_d  = (src_rest == '0);
    end else if (accept) begin
      valid_d = 1'b1;
      case (mode)
        2'b00: begin
          s_d = s_in;
          case (op_code)
            4'b1101: begin cmd_d = 4'b0001; wb_d = 1'b1; end
            4'b1111: begin cmd_d = 4'b1001; wb_d = 1'b1; end
            4'b0100: begin cmd_d = 4'b0010; wb_d = 1'b1; end
            4'b0101: begin cmd_d = 4'b0011; wb_d = 1'b1; end
            4'b0010: begin cmd_d = 4'b0100; wb_d = 1'b1; end
            4'b0110: begin cmd_d = 4'b0101; wb_d = 1'b1; end
            4'b0000: begin cmd_d = 4'b0110; wb_d = 1'b1; end
            4'b1100: begin cmd_d = 4'b0111; wb_d = 1'b1; end
            4'b0001: begin cmd_d = 4'b1000; wb_d = 1'b1; end
            4'b1010: begin cmd_d = 4'b0100; s_d = 1'b1; end
            4'b1000: begin cmd_d = 4'b0110; s_d = 1'b1; end
            default: cmd_d = 4'b0000;
          endcase
        end
        2'b01: begin
          cmd_d = 4'b0010;
          mr_d  = s_in;
          mw_d  = ~s_in;
          wb_d  = s_in;
          s_d   = s_in;
        end
        2'b10: b_d = 1'b1;
        // an empty block list falls through as a NOP
        default: valid_d = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_id_control_seq.sv
// Bench for id_control_seq: decode table, hand-written block-transfer
// sequences, and randomized traffic against a queue-based reference model.
module tb_id_control_seq;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, instr_valid, s_in;
  logic [1:0]  mode;
  logic [3:0]  op_code;
  logic [15:0] reg_list;
  logic        ready, valid_out, mem_read, mem_write, wb_en, b, s_out, xfer_last;
  logic [3:0]  exe_cmd, xfer_reg;
  logic [5:0]  xfer_offset;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr, mw, wb, bb, s;
    logic [3:0] xr;
    logic [5:0] xo;
    logic       xl;
    logic       rdy;
  } out_t;

  typedef struct {
    logic [1:0] m;
    logic [3:0] op;
    logic       s;
    out_t       exp;
  } vec_t;

  id_control_seq #(.NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .instr_valid(instr_valid), .mode(mode), .op_code(op_code), .s_in(s_in),
    .reg_list(reg_list), .ready(ready), .valid_out(valid_out),
    .exe_cmd(exe_cmd), .mem_read(mem_read), .mem_write(mem_write),
    .wb_en(wb_en), .b(b), .s_out(s_out), .xfer_reg(xfer_reg),
    .xfer_offset(xfer_offset), .xfer_last(xfer_last)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic v, input logic [3:0] cmd,
                              input logic mr, input logic mw, input logic wb,
                              input logic bb, input logic s, input logic rdy);
    out_t o = '0;
    o.v = v; o.cmd = cmd; o.mr = mr; o.mw = mw; o.wb = wb;
    o.bb = bb; o.s = s; o.rdy = rdy;
    return o;
  endfunction

  // Block micro-op: ready returns high exactly on the last one
  function automatic out_t mop(input logic l, input int r, input int ord, input logic last);
    out_t o = mk(1'b1, 4'b0010, l, ~l, l, 1'b0, 1'b0, last);
    o.xr = 4'(r);
    o.xo = 6'(ord * 4);
    o.xl = last;
    return o;
  endfunction

  function automatic out_t dp(input logic [3:0] op, input logic s);
    case (op)
      4'hD:    return mk(1, 4'd1, 0, 0, 1, 0, s, 1);
      4'hF:    return mk(1, 4'd9, 0, 0, 1, 0, s, 1);
      4'h4:    return mk(1, 4'd2, 0, 0, 1, 0, s, 1);
      4'h5:    return mk(1, 4'd3, 0, 0, 1, 0, s, 1);
      4'h2:    return mk(1, 4'd4, 0, 0, 1, 0, s, 1);
      4'h6:    return mk(1, 4'd5, 0, 0, 1, 0, s, 1);
      4'h0:    return mk(1, 4'd6, 0, 0, 1, 0, s, 1);
      4'hC:    return mk(1, 4'd7, 0, 0, 1, 0, s, 1);
      4'h1:    return mk(1, 4'd8, 0, 0, 1, 0, s, 1);
      4'hA:    return mk(1, 4'd4, 0, 0, 0, 0, 1, 1);
      4'h8:    return mk(1, 4'd6, 0, 0, 0, 0, 1, 1);
      default: return mk(1, 4'd0, 0, 0, 0, 0, s, 1);
    endcase
  endfunction

  // Reference model: pending block registers kept as a queue of indices
  int   pend[$];
  logic pl;
  int   pord;
  out_t mexp;

  task automatic model_step();
    int r;
    if (rst || flush) begin
      pend.delete();
      mexp = mk(0, 0, 0, 0, 0, 0, 0, 1);
    end else if (freeze) begin
      mexp = mexp;
    end else if (pend.size() != 0) begin
      r = pend.pop_front();
      mexp = mop(pl, r, pord, pend.size() == 0);
      pord++;
    end else if (instr_valid) begin
      case (mode)
        2'b00: mexp = dp(op_code, s_in);
        2'b01: mexp = s_in ? mk(1, 4'd2, 1, 0, 1, 0, 1, 1) : mk(1, 4'd2, 0, 1, 0, 0, 0, 1);
        2'b10: mexp = mk(1, 4'd0, 0, 0, 0, 1, 0, 1);
        default: begin
          for (int i = 0; i < 16; i++) if (reg_list[i]) pend.push_back(i);
          if (pend.size() == 0) mexp = mk(1, 0, 0, 0, 0, 0, 0, 1);
          else begin
            pl   = s_in;
            r    = pend.pop_front();
            mexp = mop(pl, r, 0, pend.size() == 0);
            pord = 1;
          end
        end
      endcase
    end else begin
      mexp = mk(0, 0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic fz, input logic v,
                     input logic [1:0] m, input logic [3:0] o, input logic si,
                     input logic [15:0] rl);
    rst = r; flush = f; freeze = fz; instr_valid = v;
    mode = m; op_code = o; s_in = si; reg_list = rl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {valid_out, exe_cmd, mem_read, mem_write, wb_en, b, s_out,
           xfer_reg, xfer_offset, xfer_last, ready};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (v%b cmd%h reg%0d off%0d last%b rdy%b) expected %h",
               name, act, act.v, act.cmd, act.xr, act.xo, act.xl, act.rdy, exp);
    end
  endtask

  vec_t vt[16];
  out_t bubble;

  initial begin
    bubble = mk(0, 0, 0, 0, 0, 0, 0, 1);
    vt[0]  = '{2'b00, 4'h4, 1'b0, mk(1, 4'd2, 0, 0, 1, 0, 0, 1)};
    vt[1]  = '{2'b00, 4'hA, 1'b0, mk(1, 4'd4, 0, 0, 0, 0, 1, 1)};
    vt[2]  = '{2'b00, 4'hD, 1'b1, mk(1, 4'd1, 0, 0, 1, 0, 1, 1)};
    vt[3]  = '{2'b00, 4'hF, 1'b0, mk(1, 4'd9, 0, 0, 1, 0, 0, 1)};
    vt[4]  = '{2'b00, 4'h5, 1'b1, mk(1, 4'd3, 0, 0, 1, 0, 1, 1)};
    vt[5]  = '{2'b00, 4'h2, 1'b0, mk(1, 4'd4, 0, 0, 1, 0, 0, 1)};
    vt[6]  = '{2'b00, 4'h6, 1'b1, mk(1, 4'd5, 0, 0, 1, 0, 1, 1)};
    vt[7]  = '{2'b00, 4'h0, 1'b0, mk(1, 4'd6, 0, 0, 1, 0, 0, 1)};
    vt[8]  = '{2'b00, 4'hC, 1'b1, mk(1, 4'd7, 0, 0, 1, 0, 1, 1)};
    vt[9]  = '{2'b00, 4'h1, 1'b0, mk(1, 4'd8, 0, 0, 1, 0, 0, 1)};
    vt[10] = '{2'b00, 4'h8, 1'b0, mk(1, 4'd6, 0, 0, 0, 0, 1, 1)};
    vt[11] = '{2'b00, 4'h3, 1'b1, mk(1, 4'd0, 0, 0, 0, 0, 1, 1)};
    vt[12] = '{2'b00, 4'hB, 1'b0, mk(1, 4'd0, 0, 0, 0, 0, 0, 1)};
    vt[13] = '{2'b01, 4'h7, 1'b1, mk(1, 4'd2, 1, 0, 1, 0, 1, 1)};
    vt[14] = '{2'b01, 4'h9, 1'b0, mk(1, 4'd2, 0, 1, 0, 0, 0, 1)};
    vt[15] = '{2'b10, 4'h4, 1'b1, mk(1, 4'd0, 0, 0, 0, 1, 0, 1)};

    cyc(1, 0, 0, 0, 2'b00, 4'h0, 0, 16'h0);
    check("reset", bubble);
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 0, 16'h0);
    check("idle_bubble", bubble);

    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, vt[i].m, vt[i].op, vt[i].s, 16'hFFFF);
      check($sformatf("decode_vec%0d", i), vt[i].exp);
    end

    // Freeze in IDLE holds the previous output and ignores the instruction
    cyc(0, 0, 0, 1, 2'b00, 4'h4, 0, 16'h0);
    cyc(0, 0, 1, 1, 2'b01, 4'h0, 1, 16'h0);
    check("freeze_idle_hold", mk(1, 4'd2, 0, 0, 1, 0, 0, 1));

    // LDM r0,r1,r3 then ADD with no gap
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h000B); check("ldm_r0", mop(1, 0, 0, 0));
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h000B); check("ldm_r1", mop(1, 1, 1, 0));
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h000B); check("ldm_r3", mop(1, 3, 2, 1));
    cyc(0, 0, 0, 1, 2'b00, 4'h4, 0, 16'h0);    check("ldm_next_add", mk(1, 4'd2, 0, 0, 1, 0, 0, 1));

    // STM with two frozen cycles after the first micro-op
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 0, 16'h000B); check("stm_r0", mop(0, 0, 0, 0));
    repeat (2) begin
      cyc(0, 0, 1, 1, 2'b11, 4'h0, 0, 16'h000B); check("stm_frozen_r0", mop(0, 0, 0, 0));
    end
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 0, 16'h000B); check("stm_r1", mop(0, 1, 1, 0));
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 0, 16'h000B); check("stm_r3", mop(0, 3, 2, 1));
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 0, 16'h0);    check("stm_after", bubble);

    // Flush while r5 is presented
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'hFFFF); check("flush_seq_r0", mop(1, 0, 0, 0));
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'hFFFF);
      check($sformatf("flush_seq_r%0d", i), mop(1, i, i, 0));
    end
    cyc(0, 1, 0, 1, 2'b00, 4'h4, 0, 16'h0); check("flush_bubble", bubble);
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 0, 16'h0); check("flush_no_issue", bubble);

    // Full list, ordinal runs to 15 without wrapping
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 2'b11, 4'h0, 0, 16'hFFFF);
      check($sformatf("full_r%0d", i), mop(0, i, i, i == 15));
    end

    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h0000); check("empty_list_nop", mk(1, 0, 0, 0, 0, 0, 0, 1));
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h8000); check("top_reg_only", mop(1, 15, 0, 1));

    // Reset mid-sequence
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h00FF); check("rst_seq_r0", mop(1, 0, 0, 0));
    cyc(0, 0, 0, 1, 2'b11, 4'h0, 1, 16'h00FF); check("rst_seq_r1", mop(1, 1, 1, 0));
    cyc(1, 0, 0, 1, 2'b11, 4'h0, 1, 16'h00FF); check("rst_midseq", bubble);
    cyc(0, 0, 0, 0, 2'b00, 4'h0, 0, 16'h0);    check("rst_after", bubble);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] rl;
      case ($urandom_range(0, 3))
        0:       rl = 16'h0001 << $urandom_range(0, 15);
        1:       rl = 16'($urandom);
        2:       rl = 16'($urandom & $urandom & $urandom);
        default: rl = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
      endcase
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
          2'($urandom), 4'($urandom), 1'($urandom), rl);
      check("random", mexp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
